rv32im_csr_file: RTL and testbench

RV32IM_CSR_FILE -- requirements
Module: rv32im_csr

---
 rtl/rv32im_csr_pkg.sv | 55 +++++
 rtl/rv32im_csr_file_if.sv | 23 ++
 rtl/rv32im_csr_counter.sv | 28 ++
 rtl/rv32im_csr_file.sv | 84 ++++++++
 tb/tb_rv32im_csr_file.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rv32im_csr_pkg.sv
// Shared constants for the RV32IM machine-mode CSR file: widths, CSR addresses,
// opcode encodings, field masks and the read-modify-write helper.
package rv32im_csr_pkg;

    localparam int XLEN       = 32;
    localparam int CSR_ADDR_W = 12;
    localparam int CSR_OP_W   = 2;

    typedef enum logic [CSR_OP_W-1:0] {
        CSR_OP_NOP = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_e;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MISA      = 12'h301;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL     = 12'h343;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIP       = 12'h344;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [CSR_ADDR_W-1:0] CSR_MVENDORID = 12'hF11;
    localparam logic [CSR_ADDR_W-1:0] CSR_MARCHID   = 12'hF12;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIMPID    = 12'hF13;
    localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

    // mstatus keeps only MIE/MPIE; MPP is hard-wired to machine mode
    localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [XLEN-1:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [XLEN-1:0] MIX_WMASK     = 32'h0000_0888;
    localparam logic [XLEN-1:0] ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] MISA_VALUE    = 32'h4000_1100;

    function automatic logic [XLEN-1:0] csr_alu(input csr_op_e op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] src);
        logic [XLEN-1:0] res;
        res = old_val;
        case (op)
            CSR_OP_RW: res = src;
            CSR_OP_RS: res = old_val | src;
            CSR_OP_RC: res = old_val & ~src;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv32im_csr_file_if.sv
// CSR access port: one address shared by the combinational read and the edge write.
interface rv32im_csr_file_if #(
    parameter int API_XLEN         = 32,
    parameter int CSR_WIDTH        = 12,
    parameter int CSR_OPCODE_WIDTH = 2
);
    logic [CSR_WIDTH-1:0]        csr_addr_i;
    logic [API_XLEN-1:0]         val_csr_i;
    logic                        we_csr_i;
    logic                        re_csr_i;
    logic [CSR_OPCODE_WIDTH-1:0] csr_opcode_i;
    logic [API_XLEN-1:0]         val_csr_o;

    modport master (
        output csr_addr_i, val_csr_i, we_csr_i, re_csr_i, csr_opcode_i,
        input  val_csr_o
    );

    modport slave (
        input  csr_addr_i, val_csr_i, we_csr_i, re_csr_i, csr_opcode_i,
        output val_csr_o
    );
endinterface

// File: rtl/rv32im_csr_counter.sv
// 64-bit free-running cycle counter; a word write wins over the increment for that
// word only, the other word still takes the carry of the unmodified count.
module rv32im_csr_counter #(
    parameter int WORD_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_lo,
    input  logic                  we_hi,
    input  logic [WORD_W-1:0]     wdata,
    output logic [2*WORD_W-1:0]   count
);
    logic [2*WORD_W-1:0] count_q;
    logic [2*WORD_W-1:0] count_inc;

    assign count_inc = count_q + 1'b1;
    assign count     = count_q;

    // rst_n_i is high-active despite its name
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q[WORD_W-1:0]        <= we_lo ? wdata : count_inc[WORD_W-1:0];
            count_q[2*WORD_W-1:WORD_W] <= we_hi ? wdata : count_inc[2*WORD_W-1:WORD_W];
        end
    end
endmodule

// File: rtl/rv32im_csr_file.sv
// Machine-mode CSR file for a small RV32IM core: combinational read mux,
// read-modify-write on the clock edge, masked fields and a 64-bit cycle counter.
module rv32im_csr_file
    import rv32im_csr_pkg::*;
#(
    parameter int API_XLEN         = 32,
    parameter int CSR_WIDTH        = 12,
    parameter int CSR_OPCODE_WIDTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    rv32im_csr_file_if.slave  csr_bus
);
    logic [API_XLEN-1:0]   mstatus_q, mie_q, mtvec_q, mscratch_q;
    logic [API_XLEN-1:0]   mepc_q, mcause_q, mtval_q, mip_q;
    logic [2*API_XLEN-1:0] cycle_count;
    logic [API_XLEN-1:0]   rdata;
    logic [API_XLEN-1:0]   wdata;
    logic                  wr_en;
    csr_op_e               op;

    assign op    = csr_op_e'(csr_bus.csr_opcode_i);
    assign wr_en = csr_bus.we_csr_i && (op != CSR_OP_NOP);
    // set/clear act on the visible value, so masked bits never leak into storage
    assign wdata = csr_alu(op, rdata, csr_bus.val_csr_i);

    always_comb begin
        rdata = '0;
        case (csr_bus.csr_addr_i)
            CSR_MSTATUS:  rdata = mstatus_q | MSTATUS_FIXED;
            CSR_MISA:     rdata = MISA_VALUE;
            CSR_MIE:      rdata = mie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MTVAL:    rdata = mtval_q;
            CSR_MIP:      rdata = mip_q;
            CSR_MCYCLE,
            CSR_CYCLE:    rdata = cycle_count[API_XLEN-1:0];
            CSR_MCYCLEH,
            CSR_CYCLEH:   rdata = cycle_count[2*API_XLEN-1:API_XLEN];
            default:      rdata = '0;
        endcase
    end

    assign csr_bus.val_csr_o = csr_bus.re_csr_i ? rdata : '0;

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
        end else if (wr_en) begin
            case (csr_bus.csr_addr_i)
                CSR_MSTATUS:  mstatus_q  <= wdata & MSTATUS_WMASK;
                CSR_MIE:      mie_q      <= wdata & MIX_WMASK;
                CSR_MTVEC:    mtvec_q    <= wdata & ALIGN_MASK;
                CSR_MSCRATCH: mscratch_q <= wdata;
                CSR_MEPC:     mepc_q     <= wdata & ALIGN_MASK;
                CSR_MCAUSE:   mcause_q   <= wdata;
                CSR_MTVAL:    mtval_q    <= wdata;
                CSR_MIP:      mip_q      <= wdata & MIX_WMASK;
                default:      ;
            endcase
        end
    end

    rv32im_csr_counter #(
        .WORD_W (API_XLEN)
    ) u_counter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_lo   (wr_en && (csr_bus.csr_addr_i == CSR_MCYCLE)),
        .we_hi   (wr_en && (csr_bus.csr_addr_i == CSR_MCYCLEH)),
        .wdata   (wdata),
        .count   (cycle_count)
    );
endmodule

// File: tb/tb_rv32im_csr_file.sv
// Scoreboard bench for rv32im_csr_file: expected read data is queued when an
// access is driven and compared when the combinational read settles.
module tb_rv32im_csr_file;
    import rv32im_csr_pkg::*;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b1;

    rv32im_csr_file_if bus ();

    rv32im_csr_file dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .csr_bus (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Independent cycle-counter model: +1 per non-reset edge, word writes override
    logic [63:0] ref_cyc = '0;
    logic [63:0] ref_nxt;
    always @(posedge clk_i) begin
        if (rst_n_i) begin
            ref_cyc <= '0;
        end else begin
            ref_nxt = ref_cyc + 64'd1;
            if (bus.we_csr_i && bus.csr_opcode_i == 2'b01 && bus.csr_addr_i == 12'hB00)
                ref_nxt[31:0] = bus.val_csr_i;
            if (bus.we_csr_i && bus.csr_opcode_i == 2'b01 && bus.csr_addr_i == 12'hB80)
                ref_nxt[63:32] = bus.val_csr_i;
            ref_cyc <= ref_nxt;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drive one access just after a rising edge, compare the read mid-cycle,
    // then let the edge commit any write.
    task automatic csr_access(input string tag, input logic [11:0] addr, input logic [1:0] op,
                              input logic we, input logic re, input logic [31:0] val,
                              input logic [31:0] exp);
        sb_item_t item;
        bus.csr_addr_i   = addr;
        bus.csr_opcode_i = op;
        bus.we_csr_i     = we;
        bus.re_csr_i     = re;
        bus.val_csr_i    = val;
        sb.push_back('{tag, exp});
        @(negedge clk_i);
        item = sb.pop_front();
        check_val(item.tag, bus.val_csr_o, item.exp);
        @(posedge clk_i);
        #1;
    endtask

    task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_access(tag, addr, 2'b00, 1'b0, 1'b1, 32'h0, exp);
    endtask

    task automatic csr_write(input string tag, input logic [11:0] addr, input logic [1:0] op,
                             input logic [31:0] val, input logic [31:0] old_val);
        csr_access(tag, addr, op, 1'b1, 1'b1, val, old_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.csr_addr_i   = '0;
        bus.csr_opcode_i = '0;
        bus.we_csr_i     = 1'b0;
        bus.re_csr_i     = 1'b0;
        bus.val_csr_i    = '0;

        // reset, with the read path still live
        rst_n_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        csr_read("rst_mstatus_live", 12'h300, 32'h0000_1800);
        rst_n_i = 1'b0;

        for (int i = 0; i < 6; i++)
            csr_read($sformatf("mcycle_inc_%0d", i), 12'hB00, i);
        csr_read("rst_mcycleh", 12'hB80, 32'h0);
        csr_read("rst_mscratch", 12'h340, 32'h0);
        csr_read("rst_mie", 12'h304, 32'h0);
        csr_read("misa", 12'h301, 32'h4000_1100);
        csr_read("mhartid", 12'hF14, 32'h0);

        csr_write("mstatus_rw1_old", 12'h300, 2'b01, 32'hF000_0000, 32'h0000_1800);
        csr_read("mstatus_rw1", 12'h300, 32'h0000_1800);
        csr_write("mstatus_rw2_old", 12'h300, 2'b01, 32'h0000_FFFF, 32'h0000_1800);
        csr_read("mstatus_rw2", 12'h300, 32'h0000_1888);
        csr_write("mstatus_rc_old", 12'h300, 2'b11, 32'h0000_0008, 32'h0000_1888);
        csr_read("mstatus_rc", 12'h300, 32'h0000_1880);

        csr_write("mscratch_rw_old", 12'h340, 2'b01, 32'hA5A5_A5A5, 32'h0);
        csr_read("mscratch_rw", 12'h340, 32'hA5A5_A5A5);
        csr_write("mscratch_rs_old", 12'h340, 2'b10, 32'h0000_000F, 32'hA5A5_A5A5);
        csr_read("mscratch_rs", 12'h340, 32'hA5A5_A5AF);
        csr_write("mscratch_rc_old", 12'h340, 2'b11, 32'hA000_0000, 32'hA5A5_A5AF);
        csr_read("mscratch_rc", 12'h340, 32'h05A5_A5AF);
        csr_access("mscratch_nop_we", 12'h340, 2'b00, 1'b1, 1'b1, 32'h1111_1111, 32'h05A5_A5AF);
        csr_access("mscratch_we0", 12'h340, 2'b01, 1'b0, 1'b1, 32'h2222_2222, 32'h05A5_A5AF);
        csr_access("re0_reads_zero", 12'h340, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        csr_read("mscratch_kept", 12'h340, 32'h05A5_A5AF);

        csr_write("mie_w", 12'h304, 2'b01, 32'hFFFF_FFFF, 32'h0);
        csr_read("mie_mask", 12'h304, 32'h0000_0888);
        csr_write("mip_w", 12'h344, 2'b01, 32'h0000_0080, 32'h0);
        csr_write("mip_rs_old", 12'h344, 2'b10, 32'h0000_0801, 32'h0000_0080);
        csr_read("mip_rs", 12'h344, 32'h0000_0880);
        csr_write("mtvec_w", 12'h305, 2'b01, 32'h0000_1003, 32'h0);
        csr_read("mtvec_align", 12'h305, 32'h0000_1000);
        csr_write("mepc_w", 12'h341, 2'b01, 32'hFFFF_FFFF, 32'h0);
        csr_read("mepc_align", 12'h341, 32'hFFFF_FFFC);
        csr_write("mcause_w", 12'h342, 2'b01, 32'h8000_000B, 32'h0);
        csr_read("mcause", 12'h342, 32'h8000_000B);
        csr_write("mtval_w", 12'h343, 2'b01, 32'hDEAD_BEEF, 32'h0);
        csr_read("mtval", 12'h343, 32'hDEAD_BEEF);

        // low-word write with carry into the high word
        csr_access("mcycle_w", 12'hB00, 2'b01, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        csr_read("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
        csr_read("mcycle_wrap", 12'hB00, 32'h0000_0000);
        csr_read("mcycleh_carry", 12'hB80, 32'h0000_0001);
        csr_read("cycleh_mirror", 12'hC80, 32'h0000_0001);
        csr_read("cycle_mirror", 12'hC00, 32'h0000_0003);
        csr_access("mcycleh_w", 12'hB80, 2'b01, 1'b1, 1'b0, 32'h0000_0005, 32'h0);
        csr_read("mcycleh_written", 12'hB80, 32'h0000_0005);
        csr_read("mcycle_model", 12'hB00, ref_cyc[31:0]);

        // read-only and unimplemented addresses
        csr_access("misa_w", 12'h301, 2'b01, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
        csr_read("misa_ro", 12'h301, 32'h4000_1100);
        csr_access("cycle_w", 12'hC00, 2'b01, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
        csr_read("cycle_ro", 12'hC00, ref_cyc[31:0]);
        csr_read("cycleh_ro", 12'hC80, ref_cyc[63:32]);
        csr_access("unimpl_w", 12'h7FF, 2'b01, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
        csr_read("unimpl_r", 12'h7FF, 32'h0);
        csr_access("mvendorid_w", 12'hF11, 2'b01, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
        csr_read("mvendorid_ro", 12'hF11, 32'h0);

        // reset wins over a simultaneous write
        rst_n_i = 1'b1;
        csr_access("rst_with_write", 12'h340, 2'b01, 1'b1, 1'b1, 32'h0000_0001, 32'h05A5_A5AF);
        rst_n_i = 1'b0;
        csr_read("rst_mscratch_cleared", 12'h340, 32'h0);
        csr_read("rst_mstatus", 12'h300, 32'h0000_1800);
        csr_read("rst_mcycle_restart", 12'hB00, 32'h0000_0002);
        csr_read("rst_mcycleh_clear", 12'hB80, 32'h0);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
